csi_rx_protocol_layer: RTL and testbench

Receive-side CSI-2 protocol layer: consumes the byte stream produced by the transmit protocol layer (after D-PHY transport), parses short and long packet headers, unpacks RAW14 payload (7 bytes → 4 pixels) and presents a pixel stream with frame framing and error flags. It sits between the D-PHY receive byte FIFO and the image sink/scoreboard, as the mirror of the transmit packer.

---
 rtl/csi_rx_protocol_layer_if.sv | 36 +++
 rtl/csi_rx_protocol_layer.sv | 197 +++++++++++++++++++
 tb/tb_csi_rx_protocol_layer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csi_rx_protocol_layer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csi_rx_protocol_layer_if                                                   |
// | Byte stream in, pixel stream out, frame status/error flags.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface csi_rx_protocol_layer_if #(
  parameter int CSI_FIFO_DATA_WIDTH = 8,
  parameter int IMAGE_PIXEL_WIDTH   = 14
);
  logic [CSI_FIFO_DATA_WIDTH-1:0] RxData;
  logic                           RxValid;
  logic                           RxReady;
  logic [IMAGE_PIXEL_WIDTH-1:0]   PixData;
  logic                           PixValid;
  logic                           PixReady;
  logic                           FrameStart;
  logic                           FrameEnd;
  logic                           FrameActive;
  logic [15:0]                    FrameNum;
  logic                           ErrWc;
  logic                           ErrSeq;

  modport master (
    output RxData, RxValid, PixReady,
    input  RxReady, PixData, PixValid, FrameStart, FrameEnd, FrameActive,
           FrameNum, ErrWc, ErrSeq
  );

  modport slave (
    input  RxData, RxValid, PixReady,
    output RxReady, PixData, PixValid, FrameStart, FrameEnd, FrameActive,
           FrameNum, ErrWc, ErrSeq
  );
endinterface
`default_nettype wire

// File: rtl/csi_rx_protocol_layer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csi_rx_protocol_layer                                                      |
// | CSI-2 receive protocol layer: header parse, RAW14 unpack, frame tracking.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module csi_rx_protocol_layer #(
  parameter int         CSI_FIFO_DATA_WIDTH   = 8,
  parameter int         IMAGE_PIXEL_WIDTH     = 14,
  parameter logic [1:0] VIRTUAL_CHANNEL       = 2'd0,
  parameter logic [5:0] FRAME_START_DATA_TYPE = 6'h00,
  parameter logic [5:0] FRAME_END_DATA_TYPE   = 6'h01,
  parameter logic [5:0] PIXEL14BITS_DATA_TYPE = 6'h2D
) (
  input wire Clk,
  input wire Reset,
  csi_rx_protocol_layer_if.slave bus
);

  localparam logic [1:0] S_HDR     = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_DROP    = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [23:0] hdr_q, hdr_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [47:0] grp_q, grp_d;
  logic [2:0]  grp_cnt_q, grp_cnt_d;
  logic [3:0][IMAGE_PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic [1:0]  pix_idx_q, pix_idx_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_end_q, frame_end_d;
  logic        frame_active_q, frame_active_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic        err_wc_q, err_wc_d;
  logic        err_seq_q, err_seq_d;

  logic [CSI_FIFO_DATA_WIDTH-1:0] rx_byte;
  logic        pix_fire, buf_draining, rx_ready, rx_fire;
  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;
  logic [55:0] grp_next;

  assign rx_byte      = bus.RxData;
  assign pix_fire     = pix_valid_q & bus.PixReady;
  assign buf_draining = pix_fire & (pix_idx_q == 2'd3);
  // Stall only when the 7th byte would arrive while the buffer still holds pixels;
  // a last-pixel handshake in the same cycle frees it, so no bubble is inserted.
  assign rx_ready     = !((grp_cnt_q == 3'd6) && pix_valid_q && !buf_draining);
  assign rx_fire      = bus.RxValid & rx_ready;
  assign hdr_vc       = hdr_q[7:6];
  assign hdr_dt       = hdr_q[5:0];
  assign hdr_wc       = hdr_q[23:8];
  assign grp_next     = {rx_byte, grp_q};

  always_comb begin
    state_d        = state_q;
    hdr_cnt_d      = hdr_cnt_q;
    hdr_d          = hdr_q;
    byte_cnt_d     = byte_cnt_q;
    grp_d          = grp_q;
    grp_cnt_d      = grp_cnt_q;
    pix_d          = pix_q;
    pix_idx_d      = pix_idx_q;
    pix_valid_d    = pix_valid_q;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    frame_active_d = frame_active_q;
    frame_num_d    = frame_num_q;
    err_wc_d       = 1'b0;
    err_seq_d      = 1'b0;

    if (pix_fire) begin
      if (pix_idx_q == 2'd3) begin
        pix_valid_d = 1'b0;
        pix_idx_d   = 2'd0;
      end else begin
        pix_idx_d = pix_idx_q + 2'd1;
      end
    end

    if (rx_fire) begin
      case (state_q)
        S_HDR: begin
          if (hdr_cnt_q != 2'd3) begin
            hdr_d     = {rx_byte, hdr_q[23:8]};
            hdr_cnt_d = hdr_cnt_q + 2'd1;
          end else begin
            // Fourth byte is the ECC, consumed without checking.
            hdr_cnt_d = 2'd0;
            if (hdr_vc != VIRTUAL_CHANNEL) begin
              if (hdr_dt >= 6'h10 && hdr_wc != 16'd0) begin
                state_d    = S_DROP;
                byte_cnt_d = hdr_wc;
              end
            end else if (hdr_dt == FRAME_START_DATA_TYPE) begin
              frame_num_d    = hdr_wc;
              frame_active_d = 1'b1;
              frame_start_d  = 1'b1;
              err_seq_d      = frame_active_q;
            end else if (hdr_dt == FRAME_END_DATA_TYPE) begin
              frame_active_d = 1'b0;
              frame_end_d    = 1'b1;
              err_seq_d      = !frame_active_q || (hdr_wc != frame_num_q);
            end else if (hdr_dt == PIXEL14BITS_DATA_TYPE) begin
              if (hdr_wc == 16'd0 || (hdr_wc % 16'd7) != 16'd0) begin
                err_wc_d = 1'b1;
                if (hdr_wc != 16'd0) begin
                  state_d    = S_DROP;
                  byte_cnt_d = hdr_wc;
                end
              end else begin
                state_d    = S_PAYLOAD;
                byte_cnt_d = hdr_wc;
              end
            end else if (hdr_dt >= 6'h10 && hdr_wc != 16'd0) begin
              state_d    = S_DROP;
              byte_cnt_d = hdr_wc;
            end
          end
        end
        S_PAYLOAD: begin
          byte_cnt_d = byte_cnt_q - 16'd1;
          if (byte_cnt_q == 16'd1) state_d = S_HDR;
          if (grp_cnt_q == 3'd6) begin
            grp_cnt_d   = 3'd0;
            pix_valid_d = 1'b1;
            pix_idx_d   = 2'd0;
            pix_d[0]    = {grp_next[31:24], grp_next[5:0]};
            pix_d[1]    = {grp_next[39:32], grp_next[11:8], grp_next[7:6]};
            pix_d[2]    = {grp_next[47:40], grp_next[17:16], grp_next[15:12]};
            pix_d[3]    = {grp_next[55:48], grp_next[23:18]};
          end else begin
            grp_d     = grp_next[55:8];
            grp_cnt_d = grp_cnt_q + 3'd1;
          end
        end
        S_DROP: begin
          byte_cnt_d = byte_cnt_q - 16'd1;
          if (byte_cnt_q == 16'd1) state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_HDR;
      hdr_cnt_q      <= 2'd0;
      hdr_q          <= 24'd0;
      byte_cnt_q     <= 16'd0;
      grp_q          <= 48'd0;
      grp_cnt_q      <= 3'd0;
      pix_q          <= '0;
      pix_idx_q      <= 2'd0;
      pix_valid_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_active_q <= 1'b0;
      frame_num_q    <= 16'd0;
      err_wc_q       <= 1'b0;
      err_seq_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_cnt_q      <= hdr_cnt_d;
      hdr_q          <= hdr_d;
      byte_cnt_q     <= byte_cnt_d;
      grp_q          <= grp_d;
      grp_cnt_q      <= grp_cnt_d;
      pix_q          <= pix_d;
      pix_idx_q      <= pix_idx_d;
      pix_valid_q    <= pix_valid_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      frame_active_q <= frame_active_d;
      frame_num_q    <= frame_num_d;
      err_wc_q       <= err_wc_d;
      err_seq_q      <= err_seq_d;
    end
  end

  assign bus.RxReady     = rx_ready;
  assign bus.PixData     = pix_q[pix_idx_q];
  assign bus.PixValid    = pix_valid_q;
  assign bus.FrameStart  = frame_start_q;
  assign bus.FrameEnd    = frame_end_q;
  assign bus.FrameActive = frame_active_q;
  assign bus.FrameNum    = frame_num_q;
  assign bus.ErrWc       = err_wc_q;
  assign bus.ErrSeq      = err_seq_q;

endmodule
`default_nettype wire

// File: tb/tb_csi_rx_protocol_layer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_csi_rx_protocol_layer                                                   |
// | Randomised packet stream checked against a packet-level reference model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_csi_rx_protocol_layer;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  csi_rx_protocol_layer_if bus ();

  csi_rx_protocol_layer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pr_mode  = 0;   // 0: PixReady low, 1: high, 2: random
  int stall_cnt = 0;

  logic [13:0] exp_pix[$];
  logic [20:0] exp_ev[$];
  logic [20:0] obs_ev[$];
  logic [7:0]  pay_q[$];
  logic        m_active;
  logic [15:0] m_num;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.PixReady = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      case (pr_mode)
        0:       bus.PixReady = 1'b0;
        1:       bus.PixReady = 1'b1;
        default: bus.PixReady = (($urandom % 4) != 0);
      endcase
    end
  end

  // Pixels are checked on handshake; status pulses are recorded for later comparison.
  initial forever begin
    @(negedge Clk);
    if (Reset === 1'b0) begin
      if (bus.PixValid && bus.PixReady) begin
        check_value("pix_expected", exp_pix.size() != 0, 1);
        if (exp_pix.size() != 0) check_value("pix_data", bus.PixData, exp_pix.pop_front());
      end
      if (bus.FrameStart || bus.FrameEnd || bus.ErrWc || bus.ErrSeq)
        obs_ev.push_back({bus.FrameStart, bus.FrameEnd, bus.ErrWc, bus.ErrSeq,
                          bus.FrameActive, bus.FrameNum});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, required completion");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Reference model: expected events and pixels for one whole packet.
  task automatic model_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           input logic [7:0] p[$]);
    int unsigned lo;
    logic [5:0]  low6;
    if (vc != 2'd0) return;
    if (dt == 6'h00) begin
      exp_ev.push_back({1'b1, 1'b0, 1'b0, m_active, 1'b1, wc});
      m_active = 1'b1;
      m_num    = wc;
    end else if (dt == 6'h01) begin
      exp_ev.push_back({1'b0, 1'b1, 1'b0, (!m_active || wc != m_num), 1'b0, m_num});
      m_active = 1'b0;
    end else if (dt == 6'h2D) begin
      if (wc == 0 || (wc % 7) != 0) begin
        exp_ev.push_back({1'b0, 1'b0, 1'b1, 1'b0, m_active, m_num});
      end else begin
        for (int g = 0; g < wc / 7; g++) begin
          lo = {8'h00, p[7*g+2], p[7*g+1], p[7*g]};
          for (int k = 0; k < 4; k++) begin
            low6 = 6'((lo >> (6 * k)) & 32'd63);
            exp_pix.push_back({p[7*g+3+k], low6});
          end
        end
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit rdy;
    int n;
    if (gaps) begin
      while (($urandom % 4) == 0) begin
        bus.RxValid = 1'b0;
        @(posedge Clk);
        #1;
      end
    end
    bus.RxData  = b;
    bus.RxValid = 1'b1;
    n = 0;
    forever begin
      @(negedge Clk);
      rdy = bus.RxReady;
      if (!rdy) stall_cnt++;
      @(posedge Clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 2000) begin
        check_value("rx_accept_timeout", rdy, 1);
        break;
      end
    end
  endtask

  task automatic build_payload(input logic [5:0] dt, input logic [15:0] wc, output logic [7:0] p[$]);
    int npay;
    npay = (dt >= 6'h10) ? int'(wc) : 0;
    p = pay_q;
    pay_q.delete();
    while (p.size() < npay) p.push_back(8'($urandom));
  endtask

  task automatic send_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input bit gaps);
    send_byte({vc, dt}, gaps);
    send_byte(wc[7:0], gaps);
    send_byte(wc[15:8], gaps);
    send_byte(8'($urandom), gaps);
  endtask

  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input bit gaps);
    logic [7:0] p[$];
    build_payload(dt, wc, p);
    model_pkt(vc, dt, wc, p);
    send_hdr(vc, dt, wc, gaps);
    foreach (p[i]) send_byte(p[i], gaps);
    bus.RxValid = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (exp_pix.size() != 0 && n < 3000) begin
      @(posedge Clk);
      n++;
    end
    check_value({tag, "_pix_drain"}, exp_pix.size(), 0);
    repeat (3) @(posedge Clk);
    check_value({tag, "_ev_count"}, obs_ev.size(), exp_ev.size());
    while (obs_ev.size() != 0 && exp_ev.size() != 0)
      check_value({tag, "_event"}, obs_ev.pop_front(), exp_ev.pop_front());
    obs_ev.delete();
    exp_ev.delete();
    @(negedge Clk);
    check_value({tag, "_frame_active"}, bus.FrameActive, m_active);
    check_value({tag, "_frame_num"}, bus.FrameNum, m_num);
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge Clk);
    check_value({tag, "_RxReady"}, bus.RxReady, 1);
    check_value({tag, "_PixValid"}, bus.PixValid, 0);
    check_value({tag, "_PixData"}, bus.PixData, 0);
    check_value({tag, "_FrameStart"}, bus.FrameStart, 0);
    check_value({tag, "_FrameEnd"}, bus.FrameEnd, 0);
    check_value({tag, "_FrameActive"}, bus.FrameActive, 0);
    check_value({tag, "_FrameNum"}, bus.FrameNum, 0);
    check_value({tag, "_ErrWc"}, bus.ErrWc, 0);
    check_value({tag, "_ErrSeq"}, bus.ErrSeq, 0);
  endtask

  initial begin
    logic [7:0]  p[$];
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          r;

    Reset       = 1'b1;
    bus.RxData  = 8'h00;
    bus.RxValid = 1'b0;
    m_active    = 1'b0;
    m_num       = 16'd0;
    repeat (3) @(posedge Clk);
    check_reset_outputs("rst");
    @(posedge Clk);
    #1;
    Reset   = 1'b0;
    pr_mode = 1;
    @(posedge Clk);
    #1;

    // Frame start / end pairing.
    send_pkt(2'd0, 6'h00, 16'h0001, 1'b0);
    settle("fs1");
    send_pkt(2'd0, 6'h01, 16'h0001, 1'b0);
    settle("fe1");

    // RAW14 unpack with single-bit-field payloads.
    pay_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(2'd0, 6'h2D, 16'd7, 1'b0);
    settle("raw_p0");
    pay_q = '{8'h00, 8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_pkt(2'd0, 6'h2D, 16'd7, 1'b0);
    settle("raw_p3");

    // Bad word count dropped, then a clean frame start.
    send_pkt(2'd0, 6'h2D, 16'd10, 1'b0);
    settle("errwc");
    send_pkt(2'd0, 6'h00, 16'h0002, 1'b0);
    settle("fs_after_errwc");

    // Sequence errors.
    send_pkt(2'd0, 6'h00, 16'h0005, 1'b0);
    send_pkt(2'd0, 6'h01, 16'h0006, 1'b0);
    settle("fe_mismatch");
    send_pkt(2'd0, 6'h01, 16'h0006, 1'b0);
    settle("fe_inactive");

    // Backpressure: two groups with the sink stalled.
    pr_mode = 0;
    repeat (2) @(posedge Clk);
    #1;
    build_payload(6'h2D, 16'd14, p);
    model_pkt(2'd0, 6'h2D, 16'd14, p);
    send_hdr(2'd0, 6'h2D, 16'd14, 1'b0);
    for (int i = 0; i < 13; i++) send_byte(p[i], 1'b0);
    @(negedge Clk);
    check_value("bp_rx_ready", bus.RxReady, 0);
    check_value("bp_pix_valid", bus.PixValid, 1);
    check_value("bp_pix_hold", bus.PixData, exp_pix[0]);
    @(posedge Clk);
    #1;
    pr_mode = 1;
    send_byte(p[13], 1'b0);
    bus.RxValid = 1'b0;
    settle("bp");

    // Reset in the middle of a payload.
    send_hdr(2'd0, 6'h2D, 16'd7, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    bus.RxValid = 1'b0;
    Reset = 1'b1;
    check_reset_outputs("midrst");
    @(posedge Clk);
    #1;
    Reset    = 1'b0;
    m_active = 1'b0;
    m_num    = 16'd0;
    exp_pix.delete();
    exp_ev.delete();
    obs_ev.delete();
    send_pkt(2'd0, 6'h00, 16'h0003, 1'b0);
    settle("fs_after_rst");

    // Full-rate stream must never stall.
    stall_cnt = 0;
    send_pkt(2'd0, 6'h2D, 16'd28, 1'b0);
    check_value("fullrate_stalls", stall_cnt, 0);
    settle("fullrate");

    // Randomised mixed traffic.
    pr_mode = 2;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom % 10;
      vc = (($urandom % 6) == 0) ? 2'($urandom) : 2'd0;
      case (r)
        0, 1: begin dt = 6'h00; wc = 16'($urandom % 4); end
        2, 3: begin dt = 6'h01; wc = (($urandom % 2) != 0) ? m_num : 16'($urandom % 4); end
        4, 5, 6: begin
          dt = 6'h2D;
          wc = (($urandom % 5) == 0) ? 16'($urandom % 22) : 16'(7 * (1 + $urandom % 4));
        end
        7: begin dt = 6'h12; wc = 16'($urandom % 9); end
        8: begin dt = 6'h05; wc = 16'($urandom); end
        default: begin dt = 6'h2D; wc = 16'd21; end
      endcase
      send_pkt(vc, dt, wc, 1'b1);
      if ((n % 4) == 3) settle("rand");
    end
    settle("rand_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
